// File: rtl/interface_tx_buffer.sv
// interface_tx_buffer: two-entry elastic transmit buffer.
// The head register always drives out_data; the tail register only holds the
// second word while the buffer is full. Handshake outputs are decoded from the
// registered state alone, so ready/valid never ripple combinationally across
// the buffer.
module interface_tx_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            count
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  w_push;
  logic                  w_pop;

  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_head;
  assign count     = r_state;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // Occupancy state machine with head/tail data movement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_head  <= in_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_head  <= in_data;
          end else if (w_push) begin
            r_tail  <= in_data;
            r_state <= TWO;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_state <= ONE;
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interface_tx_buffer.sv
// tb_interface_tx_buffer: self-checking bench for interface_tx_buffer.
// A queue holds the words the buffer should currently contain; the expected
// handshake outputs and head word are derived from its size and front entry.
module tb_interface_tx_buffer;

  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model[$];

  interface_tx_buffer #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: the model applies the handshake rules to the inputs present
  // at the rising edge, then control returns at the following falling edge.
  task automatic tick();
    bit doPush;
    bit doPop;
    @(posedge clk);
    doPush = in_valid && (model.size() < 2);
    doPop  = out_ready && (model.size() > 0);
    if (doPop) void'(model.pop_front());
    if (doPush) model.push_back(in_data);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    model.delete();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b ready=%b count=%0d data=%h, required 0 1 0 0",
               out_valid, in_ready, count, out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_push();
    in_valid = 1'b1;
    in_data = 64'hA5;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hA5 || count !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_push: valid=%b data=%h count=%0d ready=%b, required 1 a5 1 1",
               out_valid, out_data, count, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL single_drain: valid=%b count=%0d, required 0 0", out_valid, count);
    end
  endtask

  task automatic test_fill_and_drain();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h1;
    tick();
    in_data = 64'h2;
    tick();
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 64'h1) begin
      errors++;
      $display("[TB] FAIL fill_two: count=%0d ready=%b data=%h, required 2 0 1",
               count, in_ready, out_data);
    end
    in_data = 64'h3;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 2'd2 || out_data !== 64'h1) begin
      errors++;
      $display("[TB] FAIL full_ignore: count=%0d data=%h, required 2 1", count, out_data);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h2 || count !== 2'd1) begin
      errors++;
      $display("[TB] FAIL drain_second: valid=%b data=%h count=%0d, required 1 2 1",
               out_valid, out_data, count);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_empty: valid=%b count=%0d ready=%b, required 0 0 1",
               out_valid, count, in_ready);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(i) || count !== 2'd1) begin
        errors++;
        $display("[TB] FAIL stream_%0d: valid=%b data=%h count=%0d, required 1 %h 1",
                 i, out_valid, out_data, count, DW'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL stream_drain: count=%0d, required 0", count);
    end
  endtask

  task automatic test_push_pop_one();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h10;
    tick();
    in_data = 64'h11;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h11 || count !== 2'd1) begin
      errors++;
      $display("[TB] FAIL push_pop_one: valid=%b data=%h count=%0d, required 1 11 1",
               out_valid, out_data, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'hDEAD;
    tick();
    in_data = 64'hBEEF;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model.delete();
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b count=%0d ready=%b data=%h, required 0 0 1 0",
               out_valid, count, in_ready, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
        errors++;
        $display("[TB] FAIL stale_after_reset_%0d: valid=%b count=%0d, required 0 0",
                 i, out_valid, count);
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'h77;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h77) begin
      errors++;
      $display("[TB] FAIL push_after_reset: valid=%b data=%h, required 1 77", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic          prevStall;
    logic [DW-1:0] prevData;
    prevStall = 1'b0;
    prevData = '0;
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = {$urandom, $urandom};
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      tick();
      checks++;
      if (count !== 2'(model.size()) || out_valid !== (model.size() > 0) ||
          in_ready !== (model.size() < 2)) begin
        errors++;
        $display("[TB] FAIL rand_flags_%0d: count=%0d valid=%b ready=%b, required count %0d",
                 i, count, out_valid, in_ready, model.size());
      end
      if (model.size() > 0) begin
        checks++;
        if (out_data !== model[0]) begin
          errors++;
          $display("[TB] FAIL rand_order_%0d: data=%h, required %h", i, out_data, model[0]);
        end
      end
      if (prevStall) begin
        checks++;
        if (out_data !== prevData) begin
          errors++;
          $display("[TB] FAIL rand_stable_%0d: data=%h, required %h", i, out_data, prevData);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
  endtask

  // Directed scenarios followed by a long randomized run, then the summary.
  initial begin
    test_reset();
    test_single_push();
    test_fill_and_drain();
    test_stream();
    test_push_pop_one();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/interface_tx_buffer.md
INTERFACE_TX_BUFFER -- requirements
Module: interface_tx_buffer

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 64, payload width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  producer offers in_data this cycle.
REQ-005 SHALL have port: in_data  input  DATA_WIDTH  producer payload.
REQ-006 SHALL have port: in_ready  output  1  buffer accepts a word this cycle.
REQ-007 SHALL have port: out_valid  output  1  head word is presented to the consumer.
REQ-008 SHALL have port: out_data  output  DATA_WIDTH  head word.
REQ-009 SHALL have port: out_ready  input  1  consumer takes head word this cycle.
REQ-010 SHALL have port: count  output  2  current occupancy, 0..2.

Function
REQ-011 SHALL be a 2-entry elastic transmit buffer with registers head and tail, each DATA_WIDTH wide, plus a state register.
REQ-012 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-013 SHALL implement states EMPTY (count 0), ONE (count 1) and TWO (count 2), with count driven directly from state.
REQ-014 SHALL drive in_ready = (state != TWO) and out_valid = (state != EMPTY), both purely from registered state; there is no combinational path from out_ready to in_ready or from in_valid to out_valid.
REQ-015 SHALL drive out_data = head in every cycle; the value is don't-care while out_valid=0 but SHALL be stable while out_valid=1 and out_ready=0.
REQ-016 In EMPTY with push: head <= in_data; next state ONE. Without push: stay EMPTY.
REQ-017 In ONE with push only: tail <= in_data; next state TWO.
REQ-018 In ONE with pop only: next state EMPTY.
REQ-019 In ONE with push and pop in the same cycle: head <= in_data; stay ONE.
REQ-020 In ONE with neither push nor pop: hold all registers.
REQ-021 In TWO with pop: head <= tail; next state ONE. Push cannot occur in TWO.
REQ-022 In TWO without pop: hold all registers.
REQ-023 in_valid asserted while in_ready=0 SHALL be ignored; no state or data change.
REQ-024 Latency: a word pushed into EMPTY SHALL appear on out_data with out_valid=1 in the next cycle (1-cycle latency).
REQ-025 Sustained throughput SHALL be 1 word/cycle when out_ready is held high.
REQ-026 Words SHALL leave in the order accepted, with no loss or duplication.
REQ-027 The state encoding SHALL contain no unreachable state that can lock up; any illegal encoding SHALL return to EMPTY on the next edge.

Reset
REQ-028 When rst=1, the block SHALL asynchronously force state=EMPTY, head=0, tail=0, so that out_valid=0, in_ready=1, count=0 and out_data=0.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words; after release, no stale word SHALL be presented.
REQ-030 The first push SHALL be accepted in the first rising edge after rst is deasserted.

Verification
REQ-031 Reset then push 0xA5 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5, count=1, in_ready=1.
REQ-032 Push 0x1, then 0x2, with out_ready=0 -> count=2, in_ready=0; a third in_valid with 0x3 is ignored; raising out_ready yields 0x1 then 0x2, then count=0.
REQ-033 in_valid=1 and out_ready=1 for 8 cycles with data 0..7 -> out_data sequence 0..7 with 1-cycle lag, count stays 1, no bubbles.
REQ-034 In ONE holding 0x10, push 0x11 with simultaneous pop -> 0x10 consumed, next head=0x11, count=1.
REQ-035 In TWO, assert rst asynchronously between edges -> out_valid=0, count=0, in_ready=1 immediately; after release, out_valid stays 0 until a new push.
REQ-036 Random in_valid/out_ready (10k cycles) against a scoreboard queue -> in-order delivery, out_data stable while stalled, count matches model.
